nibble_add_sched: RTL and testbench

NIBBLE_ADD_SCHED -- requirements
Module: nibble_add_sched

---
 rtl/nibble_add_sched.sv | 116 +++++++++++
 tb/tb_nibble_add_sched.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/nibble_add_sched.sv
// nibble_add_sched: two-requester arbiter in front of a nibble-serial adder.
// One 4-bit adder slice is reused across NIBBLES cycles, rippling the carry
// through a register so the full W-bit sum appears after NIBBLES RUN cycles.
//
// FSM states:
//   state  | meaning
//   IDLE   | waiting for a request; grants are combinational here
//   RUN    | adding one nibble per cycle, index 0 .. NIBBLES-1
//   DONE   | one-cycle result strobe (done, done_id), then back to IDLE
module nibble_add_sched #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0,
  input  logic                   req1,
  input  logic [4*NIBBLES-1:0]   a0,
  input  logic [4*NIBBLES-1:0]   b0,
  input  logic [4*NIBBLES-1:0]   a1,
  input  logic [4*NIBBLES-1:0]   b1,
  output logic                   gnt0,
  output logic                   gnt1,
  output logic                   busy,
  output logic                   done,
  output logic                   done_id,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   co
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic          ptr;
  logic          id;
  logic [W-1:0]  opa;
  logic [W-1:0]  opb;
  logic [IW-1:0] idx;
  logic          carry;
  logic [IW+1:0] lsb;
  logic [4:0]    slice;

  // Round-robin grant: ptr only matters when both requesters contend.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst && state == S_IDLE) begin
      gnt0 = req0 & (~req1 | ~ptr);
      gnt1 = req1 & (~req0 |  ptr);
    end
  end

  // The single shared 4-bit adder slice, selected by the nibble index.
  always_comb begin
    lsb   = {idx, 2'b00};
    slice = {1'b0, opa[lsb +: 4]} + {1'b0, opb[lsb +: 4]} + {4'b0000, carry};
  end

  // Sequencer: capture on grant, one nibble per RUN cycle, strobe in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      ptr   <= 1'b0;
      id    <= 1'b0;
      opa   <= '0;
      opb   <= '0;
      idx   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      co    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (gnt0 | gnt1) begin
            opa   <= gnt1 ? a1 : a0;
            opb   <= gnt1 ? b1 : b0;
            id    <= gnt1;
            ptr   <= gnt0;
            idx   <= '0;
            carry <= 1'b0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          sum[lsb +: 4] <= slice[3:0];
          carry         <= slice[4];
          if (idx == LAST_IDX) begin
            co    <= slice[4];
            state <= S_DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Status outputs decode directly from the state and captured id.
  always_comb begin
    busy    = (state != S_IDLE);
    done    = (state == S_DONE);
    done_id = id;
  end

endmodule

// File: tb/tb_nibble_add_sched.sv
// Testbench for nibble_add_sched: directed scenarios plus randomized adds,
// checked against a whole-word arithmetic and round-robin reference model.
module tb_nibble_add_sched;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         gnt0, gnt1, busy, done, done_id, co;
  logic [W-1:0] sum;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int ptr_m = 0;
  int last_gnt_cyc;

  nibble_add_sched #(.NIBBLES(NIBBLES)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
    .done_id(done_id), .sum(sum), .co(co)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction starting in an IDLE cycle. keep: winner keeps req high.
  // raise1: requester 1 raises its request in the second RUN cycle.
  task automatic run_op(input bit r0, input bit r1,
                        input logic [W-1:0] x0, input logic [W-1:0] y0,
                        input logic [W-1:0] x1, input logic [W-1:0] y1,
                        input bit keep, input bit raise1, input string tag);
    int w;
    logic [W:0] full;
    logic [W-1:0] mask;
    req0 = r0; req1 = r1; a0 = x0; b0 = y0; a1 = x1; b1 = y1;
    #1;
    w = (r0 && r1) ? ptr_m : (r1 ? 1 : 0);
    full = (w == 1) ? ({1'b0, x1} + {1'b0, y1}) : ({1'b0, x0} + {1'b0, y0});
    chk({tag, ".gnt0"}, gnt0, (w == 0));
    chk({tag, ".gnt1"}, gnt1, (w == 1));
    last_gnt_cyc = cyc;
    step();
    ptr_m = 1 - w;
    if (!keep) begin
      if (w == 0) req0 = 1'b0; else req1 = 1'b0;
    end
    for (int i = 1; i <= NIBBLES; i++) begin
      if (raise1 && i == 2) begin
        req1 = 1'b1;
        #1;
      end
      chk({tag, ".run_busy"}, busy, 1);
      chk({tag, ".run_done"}, done, 0);
      chk({tag, ".run_gnt"}, {gnt0, gnt1}, 0);
      if (i > 1) begin
        mask = W'((1 << (4 * (i - 1))) - 1);
        chk({tag, ".partial"}, sum & mask, full[W-1:0] & mask);
      end
      step();
    end
    chk({tag, ".done"}, done, 1);
    chk({tag, ".done_id"}, done_id, w);
    chk({tag, ".sum"}, sum, full[W-1:0]);
    chk({tag, ".co"}, co, full[W]);
    chk({tag, ".done_gnt"}, {gnt0, gnt1}, 0);
    step();
    chk({tag, ".idle_busy"}, busy, 0);
    chk({tag, ".idle_done"}, done, 0);
  endtask

  initial begin
    int t0;
    bit r0, r1;
    // Reset with both requests asserted
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    step();
    chk("rst.gnt", {gnt0, gnt1}, 0);
    step();
    chk("rst.gnt2", {gnt0, gnt1}, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.sum", sum, 0);
    chk("rst.co", co, 0);
    chk("rst.done_id", done_id, 0);
    ptr_m = 0;

    // Contention held from reset release: grants alternate 0,1,0, 6 apart
    rst = 1'b0;
    run_op(1, 1, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1, 0, "cont0");
    t0 = last_gnt_cyc;
    run_op(1, 1, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1, 0, "cont1");
    chk("cont.gap1", last_gnt_cyc - t0, 6);
    t0 = last_gnt_cyc;
    run_op(1, 1, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 0, 0, "cont2");
    chk("cont.gap2", last_gnt_cyc - t0, 6);
    req0 = 1'b0; req1 = 1'b0;
    step();

    // Single add and full carry ripple
    run_op(1, 0, 16'h1234, 16'h0FFF, '0, '0, 0, 0, "single");
    chk("single.fixed", sum, 16'h2233);
    run_op(0, 1, '0, '0, 16'hFFFF, 16'h0001, 0, 0, "ripple");
    chk("ripple.fixed", {co, sum}, 17'h10000);

    // Abort in the second RUN cycle
    req0 = 1'b1; a0 = 16'h0F0F; b0 = 16'h0F0F;
    #1;
    chk("abort.gnt0", gnt0, 1);
    step();
    req0 = 1'b0;
    step();
    chk("abort.run", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    ptr_m = 0;
    #1;
    chk("abort.busy", busy, 0);
    chk("abort.done", done, 0);
    chk("abort.sum", sum, 0);
    chk("abort.co", co, 0);
    for (int k = 0; k < NIBBLES + 2; k++) begin
      step();
      chk("abort.nodone", done, 0);
    end
    run_op(1, 0, 16'hABCD, 16'h1111, '0, '0, 0, 0, "post_abort");

    // Busy ignore: req1 rises at T+2 and is granted at T+6, done at T+11
    run_op(1, 0, 16'h8000, 16'h8000, 16'h0102, 16'h0304, 0, 1, "busy_ign0");
    t0 = last_gnt_cyc;
    run_op(0, 1, '0, '0, 16'h0102, 16'h0304, 0, 0, "busy_ign1");
    chk("busy_ign.gap", last_gnt_cyc - t0, 6);

    // Randomized traffic with idle gaps
    for (int n = 0; n < 24; n++) begin
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      if (!r0 && !r1) r0 = 1'b1;
      run_op(r0, r1, W'($urandom), W'($urandom), W'($urandom), W'($urandom),
             0, 0, "rand");
      req0 = 1'b0; req1 = 1'b0;
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        step();
        chk("rand.gap_busy", busy, 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
